// File: rtl/adc_par_capture.sv
// adc_par_capture
//   Drives the sample clock of an external parallel-output ADC, registers its
//   data bus and out-of-range bit, optionally converts offset-binary to two's
//   complement, and buffers the samples in a first-word-fall-through FIFO.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enable     run the sample clock and capture
//   i_adc_data   ADC parallel data bus
//   i_adc_otr    ADC out-of-range flag
//   o_adc_clk    ADC sample clock (high for the first half of each period)
//   o_sample     formatted sample at the FIFO head
//   o_otr        out-of-range bit stored with the head sample
//   o_valid      FIFO head is meaningful
//   i_ready      consumer pops the head when o_valid & i_ready
//   o_level      FIFO occupancy, 0..2^ADDR_W
//   o_overflow   sticky: a sample was dropped because the FIFO was full
//   i_clr_ovf    clears o_overflow (a drop on the same edge wins)
module adc_par_capture #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 4,
  parameter int ADDR_W    = 4,
  parameter bit TWOS_COMP = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_adc_otr,
  output logic              o_adc_clk,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_otr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_level,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] MSB_MASK =
    TWOS_COMP ? (DATA_W'(1) << (DATA_W - 1)) : '0;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);

  // Input register and sample clock divider
  logic [DATA_W:0]   in_reg;        // {otr, data}
  logic [DIV_W-1:0]  div_cnt;
  logic              adc_clk_reg;

  // FIFO state
  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              overflow_reg;

  // Registered head
  logic [DATA_W:0]   head_reg;
  logic              valid_reg;

  // Edge controls
  logic              strobe;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [DATA_W:0]   wr_word;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   level_after_pop;
  logic              valid_next;
  logic [DATA_W:0]   head_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_reg <= '0;
    end else begin
      in_reg <= {i_adc_otr, i_adc_data};
    end
  end

  // The clock output is registered from the current count, so it reads
  // 1 for counts below half the period and 0 for the remainder.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt     <= '0;
      adc_clk_reg <= 1'b0;
    end else if (!i_enable) begin
      div_cnt     <= '0;
      adc_clk_reg <= 1'b0;
    end else begin
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      adc_clk_reg <= (div_cnt < DIV_HALF);
    end
  end

  always_comb begin
    strobe  = i_enable && (div_cnt == DIV_LAST);
    pop     = valid_reg && i_ready;
    wr_word = {in_reg[DATA_W], in_reg[DATA_W-1:0] ^ MSB_MASK};
    // A full FIFO still accepts a word when the head leaves on the same edge.
    wr_en   = strobe && ((level != LVL_FULL) || pop);
    drop    = strobe && !wr_en;
  end

  // Head selection looks at the FIFO as it stands after this edge's pop,
  // but without this edge's write, so a word written into an empty FIFO
  // surfaces one edge later. The only exception is a write that refills the
  // slot vacated by the last word: it is forwarded so the head stays valid.
  always_comb begin
    rd_next         = rd_ptr + ADDR_W'(pop);
    level_after_pop = level - (ADDR_W + 1)'(pop);
    valid_next      = (level_after_pop != '0) || (wr_en && pop);
    head_next       = (level_after_pop == '0) ? wr_word : mem[rd_next];
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow_reg <= 1'b0;
      head_reg     <= '0;
      valid_reg    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      rd_ptr <= rd_next;
      if (wr_en && !pop) begin
        level <= level + (ADDR_W + 1)'(1);
      end else if (pop && !wr_en) begin
        level <= level - (ADDR_W + 1)'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (i_clr_ovf) begin
        overflow_reg <= 1'b0;
      end
      valid_reg <= valid_next;
      if (valid_next) begin
        head_reg <= head_next;
      end
    end
  end

  assign o_adc_clk  = adc_clk_reg;
  assign o_sample   = head_reg[DATA_W-1:0];
  assign o_otr      = head_reg[DATA_W];
  assign o_valid    = valid_reg;
  assign o_level    = level;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_adc_par_capture.sv
// tb_adc_par_capture
//   Directed test of adc_par_capture with default parameters (12-bit data,
//   divide-by-4 sample clock, 16-deep FIFO, two's complement output).
//   Inputs change on the falling clock edge; outputs are examined on the
//   falling edge and pops are recorded shortly after it.
module tb_adc_par_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] adc_data = '0;
  logic        adc_otr = 1'b0;
  logic        adc_clk;
  logic [11:0] sample;
  logic        otr;
  logic        valid;
  logic        ready = 1'b0;
  logic [4:0]  level;
  logic        overflow;
  logic        clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [12:0] popped[$];

  adc_par_capture #(
    .DATA_W(12), .CLK_DIV(4), .ADDR_W(4), .TWOS_COMP(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_adc_data(adc_data), .i_adc_otr(adc_otr),
    .o_adc_clk(adc_clk), .o_sample(sample), .o_otr(otr), .o_valid(valid),
    .i_ready(ready), .o_level(level), .o_overflow(overflow),
    .i_clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Records every word the consumer takes on the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && valid && ready) popped.push_back({otr, sample});
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int j;
    logic [3:0] clk_pat;

    // Reset state, then 20 idle cycles
    #2;
    check("rst_outputs", {adc_clk, valid, level, overflow, otr, sample}, 0);
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle", {adc_clk, valid, level, overflow}, 0);
    end

    // Sample clock pattern and format conversion
    clk_pat = 4'b0011; // bit i%4: 1,1,0,0
    popped.delete();
    adc_data = 12'h800;
    ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("adc_clk_pat", adc_clk, clk_pat[i % 4]);
    end
    check("fmt_800_cnt", popped.size() > 0, 1);
    if (popped.size() > 0) check("fmt_800", popped[0], {1'b0, 12'h000});

    popped.delete();
    adc_data = 12'hFFF;
    step(8);
    check("fmt_fff_cnt", popped.size() > 0, 1);
    if (popped.size() > 0) check("fmt_fff", popped[popped.size()-1], {1'b0, 12'h7FF});

    popped.delete();
    adc_data = 12'h000;
    adc_otr = 1'b1;
    step(8);
    check("fmt_000_cnt", popped.size() > 0, 1);
    if (popped.size() > 0) check("fmt_000_otr", popped[popped.size()-1], {1'b1, 12'h800});

    // Ramp: 100 consecutive samples, no gaps or repeats
    popped.delete();
    adc_otr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      adc_data = 12'(k);
      step(4);
    end
    step(12);
    enable = 1'b0;
    step(8);
    check("ramp_drained", level, 0);
    j = -1;
    for (int i = 0; i < popped.size(); i++)
      if (j < 0 && popped[i] == 13'h0800) j = i;
    check("ramp_start", j >= 0, 1);
    check("ramp_len", (j >= 0) && (popped.size() >= j + 100), 1);
    if (j >= 0 && popped.size() >= j + 100)
      for (int k = 0; k < 100; k++)
        check("ramp", popped[j+k], {1'b0, 12'(k) ^ 12'h800});

    // Fill to 16, drop two, drain in order, clear overflow
    ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 18; k++) begin
      adc_data = 12'h100 + 12'(k);
      step(4);
    end
    enable = 1'b0;
    check("fill_level", level, 16);
    check("fill_ovf", overflow, 1);
    check("fill_head", {valid, otr, sample}, {2'b10, 12'h900});
    popped.delete();
    ready = 1'b1;
    step(20);
    check("drain_level", level, 0);
    check("drain_valid", valid, 0);
    check("drain_cnt", popped.size(), 16);
    if (popped.size() == 16)
      for (int k = 0; k < 16; k++)
        check("drain_order", popped[k], {1'b0, (12'h100 + 12'(k)) ^ 12'h800});
    check("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("ovf_clear", overflow, 0);

    // Full FIFO with a pop on the strobe edge
    ready = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      adc_data = 12'h200 + 12'(k);
      step(4);
    end
    check("full2_level", level, 16);
    adc_data = 12'h210;
    step(3);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    enable = 1'b0;
    check("fullpop_level", level, 16);
    check("fullpop_ovf", overflow, 0);
    popped.delete();
    ready = 1'b1;
    step(20);
    check("fullpop_cnt", popped.size(), 16);
    if (popped.size() == 16) begin
      check("fullpop_first", popped[0], {1'b0, 12'hA01});
      check("fullpop_last", popped[15], {1'b0, 12'hA10});
    end
    check("fullpop_drained", level, 0);

    // Asynchronous reset with 5 words buffered
    ready = 1'b0;
    adc_data = 12'h345;
    enable = 1'b1;
    step(20);
    check("pre_rst_level", level, 5);
    step(1);
    check("pre_rst_adc_clk", adc_clk, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", {valid, level, adc_clk, overflow}, 0);
    step(1);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("first_strobe", level, (i == 4) ? 1 : 0);
    end

    // Level 1 with a write and a pop on the same edge
    step(1);
    check("lvl1_valid", {valid, sample}, {1'b1, 12'hB45});
    adc_data = 12'h0AB;
    step(2);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("wr_pop_level", level, 1);
    step(1);
    check("wr_pop_head", {valid, otr, sample}, {2'b10, 12'h8AB});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    $fatal(1);
  end

endmodule
